// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the bit-serial ALU responder:
//   - ALUOp encodings (same as the combinational 6-bit ALU)
//   - responder FSM state enum
//   - opcode classification helpers
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_NOR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // True for the five opcodes the ALU defines.
    function automatic logic is_legal_op(input logic [3:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
               (op == OP_SUB) || (op == OP_NOR);
    endfunction

    // Only the arithmetic opcodes report a carry out.
    function automatic logic is_arith_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// ---------------------------------------------------------------------------
// alu_bit_slice
// One-bit ALU cell. Operand inversion is applied first, then op selects
// AND / OR / full-adder sum. The adder carry is always produced.
// Ports:
//   a, b     in   operand bits
//   cin      in   carry into this bit
//   Ainvert  in   invert a before the function
//   Bnegate  in   invert b before the function
//   op       in   00 AND, 01 OR, 10 SUM, 11 -> 0
//   res      out  result bit
//   cout     out  carry out of the full adder
// ---------------------------------------------------------------------------
module alu_bit_slice (
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic       Ainvert,
    input  logic       Bnegate,
    input  logic [1:0] op,
    output logic       res,
    output logic       cout
);

    logic ai;
    logic bi;

    assign ai   = a ^ Ainvert;
    assign bi   = b ^ Bnegate;
    assign cout = (ai & bi) | (ai & cin) | (bi & cin);

    always_comb begin
        res = 1'b0;
        case (op)
            2'b00:   res = ai & bi;
            2'b01:   res = ai | bi;
            2'b10:   res = ai ^ bi ^ cin;
            default: res = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_serial_responder.sv
// ---------------------------------------------------------------------------
// alu_serial_responder
// Bit-serial ALU behind a valid/ready request/response handshake. One result
// bit is computed per clock, LSB first, by a single reused alu_bit_slice.
// Accept at edge T -> rsp_valid high after edge T+WIDTH; response held until
// rsp_ready, then back to IDLE (req_ready returns the cycle after).
//
// Optional feature: define ALU_ZERO_FLAG_EN to add the Zero output
// (combinational Result == 0).
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req_valid/req_ready request handshake (req_ready high only in IDLE)
//   a, b, CarryIn       operands and carry into bit 0 (ADD only)
//   ALUOp               0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR
//   rsp_valid/rsp_ready response handshake
//   Result, CarryOut    result and carry out (0 for non-arithmetic ops)
//   rsp_err             ALUOp was illegal (Result/CarryOut forced to 0)
//   Zero                [ALU_ZERO_FLAG_EN] Result == 0
// ---------------------------------------------------------------------------
module alu_serial_responder
    import alu_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             CarryIn,
    input  logic [3:0]       ALUOp,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] Result,
    output logic             CarryOut,
`ifdef ALU_ZERO_FLAG_EN
    output logic             Zero,
`endif
    output logic             rsp_err
);

    localparam int            IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       op_q;
    logic             carry_q;   // running carry into bit idx
    logic             err_q;     // captured illegal-opcode flag
    logic [IW-1:0]    idx;

    logic             s_res;
    logic             s_cout;

    // Single slice, fed from the captured operands at the current bit index.
    alu_bit_slice u_slice (
        .a       (a_q[idx]),
        .b       (b_q[idx]),
        .cin     (carry_q),
        .Ainvert (op_q[3]),
        .Bnegate (op_q[2]),
        .op      (op_q[1:0]),
        .res     (s_res),
        .cout    (s_cout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= OP_AND;
            carry_q   <= 1'b0;
            err_q     <= 1'b0;
            Result    <= '0;
            CarryOut  <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        a_q       <= a;
                        b_q       <= b;
                        op_q      <= ALUOp;
                        // Subtraction needs the +1 of two's complement, so a
                        // negated b forces the initial carry high.
                        carry_q   <= ALUOp[2] | CarryIn;
                        err_q     <= ~is_legal_op(ALUOp);
                        idx       <= '0;
                        Result    <= '0;
                        CarryOut  <= 1'b0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b0;
                        state     <= BUSY;
                    end
                end

                BUSY: begin
                    // Illegal opcodes still walk every bit but write zeros.
                    Result[idx] <= s_res & ~err_q;
                    carry_q     <= s_cout;
                    idx         <= idx + 1'b1;
                    if (idx == LAST) begin
                        CarryOut  <= s_cout & is_arith_op(op_q);
                        rsp_err   <= err_q;
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end
                end

                DONE: begin
                    // Outputs hold here until the consumer takes them.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef ALU_ZERO_FLAG_EN
    assign Zero = (Result == '0);
`endif

endmodule

// File: tb/tb_alu_serial_responder.sv
// ---------------------------------------------------------------------------
// tb_alu_serial_responder
// Scoreboarded bench: the driver pushes the expected response (from an
// arithmetic reference model) at acceptance; a monitor pops and compares on
// every response handshake. Directed cases cover the opcode table, latency,
// issue interval, back-pressure and reset mid-operation; then random ops.
// ---------------------------------------------------------------------------
module tb_alu_serial_responder;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic         cin_i = 1'b0;
    logic [3:0]   op_i = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] Result;
    logic         CarryOut;
    logic         rsp_err;
`ifdef ALU_ZERO_FLAG_EN
    logic         Zero;
`endif

    alu_serial_responder #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .a         (a_i),
        .b         (b_i),
        .CarryIn   (cin_i),
        .ALUOp     (op_i),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .Result    (Result),
        .CarryOut  (CarryOut),
`ifdef ALU_ZERO_FLAG_EN
        .Zero      (Zero),
`endif
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         co;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   rdy_mode = 1;   // 0 random, 1 always ready, 2 hold off

    // Reference model: plain integer arithmetic on the opcode meaning.
    function automatic exp_t model(input int av, input int bv, input int cv, input logic [3:0] op);
        exp_t e;
        int   s;
        e.res = '0; e.co = 1'b0; e.err = 1'b0;
        case (op)
            4'b0000: e.res = W'(av & bv);
            4'b0001: e.res = W'(av | bv);
            4'b0010: begin s = av + bv + cv;             e.res = W'(s % 64); e.co = (s >= 64); end
            4'b0110: begin s = av + (63 - bv) + 1;       e.res = W'(s % 64); e.co = (s >= 64); end
            4'b1100: e.res = W'(63 - (av | bv));
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // rsp_ready driver, changed just after each active edge.
    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       rsp_ready = ($urandom_range(0, 3) != 0);
            1:       rsp_ready = 1'b1;
            default: rsp_ready = 1'b0;
        endcase
    end

    // Monitor: compares on each handshake; also checks rsp_valid never
    // drops while back-pressured.
    initial begin
        logic hold_prev;
        exp_t e;
        hold_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (hold_prev && !reset) check("rsp_valid_hold", rsp_valid, 1);
            hold_prev = rsp_valid && !rsp_ready && !reset;
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("Result",   Result,   e.res);
                    check("CarryOut", CarryOut, e.co);
                    check("rsp_err",  rsp_err,  e.err);
`ifdef ALU_ZERO_FLAG_EN
                    check("Zero",     Zero,     (e.res == 0));
`endif
                end
            end
        end
    end

    // Wait for req_ready, present one request, return acceptance time.
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic cv, input logic [3:0] op,
                         input bit push, output time acc_t);
        int w = 0;
        @(negedge clk);
        while (!req_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) begin
            check("req_ready_timeout", 0, 1);
            acc_t = $time;
            return;
        end
        req_valid = 1'b1;
        a_i = av; b_i = bv; cin_i = cv; op_i = op;
        @(posedge clk);
        acc_t = $time;
        if (push) sb.push_back(model(int'(av), int'(bv), int'(cv), op));
        #1;
        // Scramble inputs: they must not affect the accepted operation.
        req_valid = 1'b0;
        a_i = W'($urandom); b_i = W'($urandom); cin_i = 1'($urandom); op_i = 4'($urandom);
    endtask

    // Cycles from acceptance edge until rsp_valid is seen high.
    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!rsp_valid && lat < 40);
    endtask

    logic [3:0] legal_ops [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100};
    logic [3:0] plan_ops  [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100, 4'b0011};

    initial begin
        time t1, t2;
        int  lat;
        logic [W-1:0] r0;
        int  w;
        logic [3:0] op;

        // Reset state.
        rdy_mode = 1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_req_ready", req_ready, 1);
        check("rst_Result",    Result,    0);
        check("rst_CarryOut",  CarryOut,  0);
        check("rst_rsp_err",   rsp_err,   0);
`ifdef ALU_ZERO_FLAG_EN
        check("rst_Zero",      Zero,      1);
`endif

        // Opcode table with a=111111, b=000000, CarryIn=1.
        foreach (plan_ops[k]) begin
            issue(6'b111111, 6'b000000, 1'b1, plan_ops[k], 1, t1);
            wait_rsp(lat);
            check("latency", lat, 6);
        end

        // Minimum issue interval with an always-ready consumer.
        issue(W'($urandom), W'($urandom), 1'b0, OP_ADD_TB(), 1, t1);
        issue(W'($urandom), W'($urandom), 1'b1, 4'b0110, 1, t2);
        check("issue_interval", 32'((t2 - t1) / 10), 8);
        wait_rsp(lat);

        // Back-pressure: hold 10 cycles, a second request must be ignored.
        rdy_mode = 2;
        issue(6'b111111, 6'b000000, 1'b1, 4'b0001, 1, t1);
        wait_rsp(lat);
        r0 = Result;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_Result",    Result,    r0);
            check("bp_req_ready", req_ready, 0);
            req_valid = 1'b1;
            a_i = W'($urandom); b_i = W'($urandom); op_i = 4'b0010;
        end
        req_valid = 1'b0;
        rdy_mode = 1;
        w = 0;
        while (rsp_valid && w < 20) begin @(negedge clk); w++; end
        // If the ignored request had been taken, a response would appear.
        repeat (10) @(negedge clk);
        check("bp_no_extra_rsp", rsp_valid, 0);

        // Reset 3 cycles into BUSY abandons the operation.
        issue(6'b010101, 6'b001100, 1'b0, 4'b0010, 0, t1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_Result",    Result,    0);
        check("mid_rst_req_ready", req_ready, 1);
        repeat (8) @(negedge clk);
        check("mid_rst_no_rsp", rsp_valid, 0);
        issue(6'b000011, 6'b000001, 1'b0, 4'b0010, 1, t1);
        wait_rsp(lat);
        check("post_rst_latency", lat, 6);
        check("post_rst_add", Result, 6'b000100);

        // Randomized operations, some illegal, with a random consumer.
        for (int n = 0; n < 40; n++) begin
            rdy_mode = int'($urandom_range(0, 1));
            op = ($urandom_range(0, 5) == 0) ? 4'($urandom) : legal_ops[$urandom_range(0, 4)];
            issue(W'($urandom), W'($urandom), 1'($urandom), op, 1, t1);
            wait_rsp(lat);
            check("rand_latency", lat, 6);
        end

        rdy_mode = 1;
        w = 0;
        while (sb.size() != 0 && w < 100) begin @(negedge clk); w++; end
        check("sb_drain", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    function automatic logic [3:0] OP_ADD_TB();
        return 4'b0010;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
